mdu_hilo: RTL and testbench
===========================

// Module: mdu_hilo
// PURPOSE
//  Multiply/divide unit plus the architectural HI/LO registers for the MIPS datapath. Sits beside the ALU in E.
//  - Accepts mult/multu/div/divu from E and serves mfhi/mflo reads in E.
//  - Applies mthi/mtlo writes from M.
//  - Raises a stall request while an operation is in flight.
// PARAMETERS
//  MUL_LAT  2   cycles from accept to DONE for mult/multu (legal 1..8)
//  CNT_W    6   iteration counter width (must hold 33)
// PORTS
//  clk       in   1   clock, all state updates on rising edge
//  rst       in   1   synchronous, active-low reset (rst==0 at posedge resets)
//  start_i   in   1   E holds a mult/div op (held high while E is stalled)
//  op_i      in   2   00 mult, 01 multu, 10 div, 11 divu
//  a_i       in   32  rs operand (dividend / multiplicand)
//  b_i       in   32  rt operand (divisor / multiplier)
//  stallE_i  in   1   E stalled by another source
//  flush_i   in   1   E flush (exception/squash); aborts current op
//  mthi_i    in   1   M-stage mthi
//  mtlo_i    in   1   M-stage mtlo
//  wdata_i   in   32  M-stage rs value for mthi/mtlo
//  hi_o      out  32  HI for mfhi in E; mthi_i ? wdata_i : hi_q
//  lo_o      out  32  LO for mflo in E; mtlo_i ? wdata_i : lo_q
//  stall_o   out  1   stall request to hazard unit
//  busy_o    out  1   state is MUL or DIV
// BEHAVIOUR
//  Reset: state=IDLE, hi_q=lo_q=0, counter=0; stall_o=0, busy_o=0.
//  States and transitions:
//  - IDLE: start_i & ~flush_i latches op, operands and operand signs, then branches:
//      mult/multu -> MUL
//      div/divu with b_i!=0 -> DIV
//      div/divu with b_i==0 -> DONE
//  - MUL: count MUL_LAT-1 further cycles; the 64b product is registered; then -> DONE.
//  - DIV: restoring radix-2 on magnitudes (signed ops); one quotient bit per cycle; 32 cycles, then -> DONE.
//  - DONE: on entry, HI/LO are written exactly once.
//      mult*: HI=prod[63:32], LO=prod[31:0]
//      div*:  LO=quotient, HI=remainder; remainder takes the dividend's sign
//      Divide by zero: HI=a, LO=32'hFFFF_FFFF.
//      Stays in DONE while stallE_i=1 (no re-accept of the held start_i).
//      -> IDLE when stallE_i=0.
//  stall_o = (IDLE & start_i & ~flush_i) | MUL | DIV. stall_o is 0 in DONE, so E advances on the exit edge.
//  Latencies:
//  - mult: E is held MUL_LAT+1 cycles total, accept cycle included.
//  - div (b!=0): E is held 34 cycles.
//  - div by zero: E is held 2 cycles.
//  flush_i: in any state, -> IDLE next edge. The HI/LO write of that cycle is suppressed. stall_o=0 during flush.
//  mthi/mtlo (the M-stage instruction is older):
//  - Written at the edge in any state.
//  - Same edge as the DONE write: the DONE write wins for both HI and LO.
//  Signed arithmetic:
//  - mult: 64b signed product.
//  - div: -2^31 / -1 gives LO=32'h8000_0000, HI=0, with no trap.
//  Reset mid-operation: abort immediately; all state returns to reset values.
// CONFIGURATION
//  MDU_DIV_EN defined: full divide path as above.
//  MDU_DIV_EN undefined:
//  - DIV state and divider logic are removed.
//  - div/divu go IDLE->DONE with HI/LO unchanged (no-op, 2-cycle hold).
//  - mult path is unaffected.
// TESTING
//  1 reset: rst=0 for 2 cycles -> hi_o=lo_o=0, stall_o=0, busy_o=0.
//  2 mult a=32'hFFFF_FFFE (-2), b=3, MUL_LAT=2:
//    - stall_o high 2 cycles, then DONE.
//    - HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFA.
//    - multu, same operands: HI=2, LO=32'hFFFF_FFFA.
//  3 div a=-7, b=2:
//    - stall_o high 33 cycles, then DONE.
//    - LO=32'hFFFF_FFFD (-3), HI=32'hFFFF_FFFF (-1).
//    - divu 100/7: LO=14, HI=2.
//  4 divu b=0, a=5:
//    - 1 stall cycle.
//    - HI=5, LO=32'hFFFF_FFFF.
//    - With MDU_DIV_EN undefined: HI/LO keep prior values.
//  5 DONE with stallE_i=1 for 3 cycles, start_i held:
//    - Single HI/LO write, no second op.
//    - -> IDLE when stallE_i drops.
//  6 flush_i at DIV cycle 10:
//    - IDLE next cycle, HI/LO unchanged, stall_o=0.
//  6 mthi wdata=32'h1234 with mfhi in E:
//    - hi_o=32'h1234 same cycle.
//  6 mtlo on the same edge as a mult DONE write:
//    - LO = product.

Source files
------------

// File: rtl/mdu_hilo_if.sv
// mdu_hilo_if: E/M-stage connection bundle for the multiply/divide unit.
//
// Handshake: start_i acts as "valid" from E and is held high for as long as
// the mult/div instruction sits in E. The unit answers with stall_o acting as
// an inverted "ready": the op is complete and E may advance on any cycle
// where start_i=1 and stall_o=0 (the DONE cycle). flush_i withdraws the
// request unconditionally.
interface mdu_hilo_if;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        stallE_i;
    logic        flush_i;
    logic        mthi_i;
    logic        mtlo_i;
    logic [31:0] wdata_i;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        stall_o;
    logic        busy_o;
    logic [1:0]  state_o;

    modport master (
        output start_i, op_i, a_i, b_i, stallE_i, flush_i, mthi_i, mtlo_i, wdata_i,
        input  hi_o, lo_o, stall_o, busy_o, state_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i, stallE_i, flush_i, mthi_i, mtlo_i, wdata_i,
        output hi_o, lo_o, stall_o, busy_o, state_o
    );
endinterface

// File: rtl/mdu_hilo.sv
// mdu_hilo: MIPS multiply/divide unit plus architectural HI/LO registers.
// Optional feature macro: MDU_DIV_EN builds the restoring radix-2 divider;
// without it div/divu pass IDLE->DONE leaving HI/LO untouched.
// state_o exposes the FSM state (0 IDLE, 1 MUL, 2 DIV, 3 DONE).
module mdu_hilo #(
    parameter int MUL_LAT = 2,
    parameter int CNT_W   = 6
) (
    input logic       clk,
    input logic       rst,
    mdu_hilo_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Last MUL-state count value; unused when MUL_LAT==1 (MUL is skipped).
    localparam logic [CNT_W-1:0] MUL_END = CNT_W'(MUL_LAT >= 2 ? MUL_LAT - 2 : 0);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic [63:0]      prod;
    logic [63:0]      prod_q;
    logic             mul_sgn;
    logic             wr_en;
    logic [31:0]      wr_hi;
    logic [31:0]      wr_lo;
    logic             accept;
    logic             mul_last;

    assign accept   = (state == S_IDLE) && bus.start_i && !bus.flush_i;
    assign mul_last = (state == S_MUL) && (cnt == MUL_END);

    // Product is formed from the E operands on the accept cycle and then registered.
    assign mul_sgn = !bus.op_i[0];
    assign prod    = {{32{mul_sgn & bus.a_i[31]}}, bus.a_i} * {{32{mul_sgn & bus.b_i[31]}}, bus.b_i};

`ifdef MDU_DIV_EN
    localparam logic [CNT_W-1:0] DIV_END = CNT_W'(31);

    logic        sa_q;
    logic        sb_q;
    logic [31:0] dvs_q;
    logic [31:0] quo_q;
    logic [31:0] rem_q;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic        ge;
    logic [31:0] quo_nx;
    logic [31:0] rem_nx;
    logic        div_last;
    logic        a_neg;
    logic        b_neg;

    assign a_neg    = !bus.op_i[0] && bus.a_i[31];
    assign b_neg    = !bus.op_i[0] && bus.b_i[31];
    assign div_last = (state == S_DIV) && (cnt == DIV_END);

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    assign shifted = {rem_q, quo_q[31]};
    assign diff    = shifted - {1'b0, dvs_q};
    assign ge      = !diff[32];
    assign rem_nx  = ge ? diff[31:0] : shifted[31:0];
    assign quo_nx  = {quo_q[30:0], ge};

    // Divider datapath: load magnitudes on accept, iterate while in DIV.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sa_q  <= 1'b0;
            sb_q  <= 1'b0;
            dvs_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
        end else if (accept) begin
            sa_q  <= a_neg;
            sb_q  <= b_neg;
            dvs_q <= b_neg ? -bus.b_i : bus.b_i;
            quo_q <= a_neg ? -bus.a_i : bus.a_i;
            rem_q <= '0;
        end else if (state == S_DIV) begin
            quo_q <= quo_nx;
            rem_q <= rem_nx;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    // Next-state logic; a flush returns to IDLE from anywhere.
    always_comb begin
        state_nx = state;
        if (bus.flush_i) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        if (!bus.op_i[1])
                            state_nx = (MUL_LAT == 1) ? S_DONE : S_MUL;
`ifdef MDU_DIV_EN
                        else
                            state_nx = (bus.b_i != 32'd0) ? S_DIV : S_DONE;
`else
                        else
                            state_nx = S_DONE;
`endif
                    end
                end
                S_MUL:  if (mul_last) state_nx = S_DONE;
`ifdef MDU_DIV_EN
                S_DIV:  if (div_last) state_nx = S_DONE;
`endif
                S_DONE: if (!bus.stallE_i) state_nx = S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // Outputs and the single HI/LO result write on the edge entering DONE.
    always_comb begin
        wr_en       = 1'b0;
        wr_hi       = prod_q[63:32];
        wr_lo       = prod_q[31:0];
        bus.stall_o = !bus.flush_i && (accept || state == S_MUL || state == S_DIV);
        bus.busy_o  = (state == S_MUL) || (state == S_DIV);
        bus.state_o = state;
        if (!bus.flush_i) begin
            if (accept && !bus.op_i[1] && MUL_LAT == 1) begin
                wr_en = 1'b1;
                wr_hi = prod[63:32];
                wr_lo = prod[31:0];
            end else if (mul_last) begin
                wr_en = 1'b1;
            end
`ifdef MDU_DIV_EN
            if (accept && bus.op_i[1] && bus.b_i == 32'd0) begin
                wr_en = 1'b1;
                wr_hi = bus.a_i;
                wr_lo = 32'hFFFF_FFFF;
            end else if (div_last) begin
                wr_en = 1'b1;
                wr_hi = sa_q ? -rem_nx : rem_nx;
                wr_lo = (sa_q ^ sb_q) ? -quo_nx : quo_nx;
            end
`endif
        end
    end

    // Iteration counter: cleared on accept, advances in MUL/DIV.
    always_ff @(posedge clk) begin
        if (!rst || bus.flush_i) cnt <= '0;
        else if (accept) cnt <= '0;
        else if (state == S_MUL || state == S_DIV) cnt <= cnt + CNT_W'(1);
    end

    // Registered product captured when a mult is accepted.
    always_ff @(posedge clk) begin
        if (!rst) prod_q <= '0;
        else if (accept) prod_q <= prod;
    end

    // HI/LO: M-stage moves write every edge, but a same-edge result write wins.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (bus.mthi_i) hi_q <= bus.wdata_i;
            if (bus.mtlo_i) lo_q <= bus.wdata_i;
            if (wr_en) begin
                hi_q <= wr_hi;
                lo_q <= wr_lo;
            end
        end
    end

    // mfhi/mflo see an in-flight M-stage move.
    assign bus.hi_o = bus.mthi_i ? bus.wdata_i : hi_q;
    assign bus.lo_o = bus.mtlo_i ? bus.wdata_i : lo_q;
endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: randomized scoreboard bench for mdu_hilo.
// Build with or without +define+MDU_DIV_EN; the reference model follows the macro.
module tb_mdu_hilo;
    localparam int MUL_LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mdu_hilo_if bus ();

    mdu_hilo #(.MUL_LAT(MUL_LAT), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [63:0] exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] hi_m  = '0;
    logic [31:0] lo_m  = '0;
    logic        seen  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural result of one op as {HI, LO}.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] hi,
                                          input logic [31:0] lo);
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == 2'd0) return 64'(sa * sb);
        if (op == 2'd1) return {32'd0, a} * {32'd0, b};
`ifdef MDU_DIV_EN
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (op == 2'd2) begin
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
`else
        q = 0;
        r = 0;
        return {hi, lo};
`endif
    endfunction

    function automatic int exp_stalls(input logic [1:0] op, input logic [31:0] b);
        if (!op[1]) return MUL_LAT;
`ifdef MDU_DIV_EN
        if (b != 32'd0) return 33;
`endif
        return 1;
    endfunction

    // Monitor: the op completes on the first cycle with start held and no stall.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (rst && bus.start_i && !bus.stall_o && !bus.flush_i) begin
                if (!seen) begin
                    seen = 1'b1;
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_done: got %h expected none", {bus.hi_o, bus.lo_o});
                    end else begin
                        e = exp_q.pop_front();
                        check("done_hilo", {bus.hi_o, bus.lo_o}, e);
                    end
                end
            end else if (!bus.start_i) begin
                seen = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic idle_check(input string name);
        check({name, "_stall"}, 64'(bus.stall_o), 64'd0);
        check({name, "_busy"}, 64'(bus.busy_o), 64'd0);
        check({name, "_hilo"}, {bus.hi_o, bus.lo_o}, {hi_m, lo_m});
    endtask

    // One op; hold = extra DONE cycles under stallE; mt = mtlo on the result-write edge.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input bit mt);
        logic [63:0] e;
        int st, xs;
        bit done;
        e  = model(op, a, b, hi_m, lo_m);
        xs = exp_stalls(op, b);
        @(posedge clk); #1;
        bus.start_i  = 1'b1;
        bus.op_i     = op;
        bus.a_i      = a;
        bus.b_i      = b;
        bus.stallE_i = (hold > 0);
        exp_q.push_back(e);
        hi_m = e[63:32];
        lo_m = e[31:0];
        st   = 0;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (!bus.stall_o) begin
                done = 1'b1;
            end else begin
                st++;
                if (mt && st == xs - 1) begin
                    @(posedge clk); #1;
                    bus.mtlo_i  = 1'b1;
                    bus.wdata_i = $urandom;
                    @(negedge clk);
                    if (bus.stall_o) st++;
                    @(posedge clk); #1;
                    bus.mtlo_i  = 1'b0;
                end
            end
        end
        check("stall_cycles", 64'(st), 64'(xs));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_stall", 64'(bus.stall_o), 64'd0);
            check("hold_hilo", {bus.hi_o, bus.lo_o}, e);
        end
        @(posedge clk); #1;
        bus.start_i  = 1'b0;
        bus.stallE_i = 1'b0;
        if (hold > 0) @(posedge clk);
        @(negedge clk);
        idle_check("after_op");
        check("after_state", 64'(bus.state_o), 64'd0);
        check("sb_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Abort an op with flush after `at` cycles past the accept cycle.
    task automatic flush_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input int at);
        @(posedge clk); #1;
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.a_i     = a;
        bus.b_i     = b;
        repeat (at) @(posedge clk);
        #1;
        bus.flush_i = 1'b1;
        bus.start_i = 1'b0;
        @(negedge clk);
        check("flush_stall", 64'(bus.stall_o), 64'd0);
        @(posedge clk); #1;
        bus.flush_i = 1'b0;
        @(negedge clk);
        idle_check("post_flush");
        check("post_flush_state", 64'(bus.state_o), 64'd0);
        repeat (4) @(negedge clk);
        check("post_flush_late", {bus.hi_o, bus.lo_o}, {hi_m, lo_m});
    endtask

    task automatic move_check(input bit to_hi, input logic [31:0] w);
        @(posedge clk); #1;
        bus.wdata_i = w;
        if (to_hi) bus.mthi_i = 1'b1;
        else       bus.mtlo_i = 1'b1;
        @(negedge clk);
        if (to_hi) check("mthi_bypass", 64'(bus.hi_o), 64'(w));
        else       check("mtlo_bypass", 64'(bus.lo_o), 64'(w));
        @(posedge clk); #1;
        bus.mthi_i = 1'b0;
        bus.mtlo_i = 1'b0;
        if (to_hi) hi_m = w;
        else       lo_m = w;
        @(negedge clk);
        check("move_written", {bus.hi_o, bus.lo_o}, {hi_m, lo_m});
    endtask

    initial begin
        logic [31:0] corner[6];
        logic [31:0] a, b;
        corner = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFE};
        bus.start_i = 1'b0; bus.op_i = 2'd0; bus.a_i = '0; bus.b_i = '0;
        bus.stallE_i = 1'b0; bus.flush_i = 1'b0; bus.mthi_i = 1'b0; bus.mtlo_i = 1'b0;
        bus.wdata_i = '0;

        // Reset
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
        check("rst_stall", 64'(bus.stall_o), 64'd0);
        check("rst_busy", 64'(bus.busy_o), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Directed cases
        run_op(2'd0, 32'hFFFF_FFFE, 32'd3, 0, 1'b0);
        run_op(2'd1, 32'hFFFF_FFFE, 32'd3, 0, 1'b0);
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
        run_op(2'd3, 32'd100, 32'd7, 0, 1'b0);
        run_op(2'd3, 32'd5, 32'd0, 0, 1'b0);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        run_op(2'd0, 32'h0000_1234, 32'h0000_5678, 3, 1'b0);
        move_check(1'b1, 32'h0000_1234);
        move_check(1'b0, 32'hCAFE_0001);
        run_op(2'd0, 32'h0001_0003, 32'hFFFF_0007, 0, 1'b1);
        flush_op(2'd0, 32'd9, 32'd9, 1);
`ifdef MDU_DIV_EN
        flush_op(2'd3, 32'd1000, 32'd3, 10);
`endif

        // Randomized ops
        for (int n = 0; n < 40; n++) begin
            a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            run_op(2'($urandom_range(0, 3)), a, b, $urandom_range(0, 3), 1'b0);
        end

        // Reset in the middle of an op
        @(posedge clk); #1;
        bus.start_i = 1'b1; bus.op_i = 2'd1; bus.a_i = 32'd77; bus.b_i = 32'd3;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.start_i = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        hi_m = '0;
        lo_m = '0;
        @(negedge clk);
        idle_check("mid_reset");

        check("final_sb_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
